// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit between a core request port and a fixed-latency data memory
module lsu #(
    parameter int READ_LAT = 2,
    parameter int ADDR_W   = 14
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_sign_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [1:0]        mem_size_o,
    output logic              mem_sign_o,
    output logic              mem_write_o,
    input  logic [31:0]       mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    localparam int CW = $clog2(READ_LAT + 2);
    localparam logic [CW-1:0] LAT = CW'(READ_LAT);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wr2_q, wr2_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [1:0]        mem_size_q, mem_size_d;
    logic              mem_sign_q, mem_sign_d;
    logic              mem_write_q, mem_write_d;
    logic              accept, err;

    assign accept = req_valid_i & req_ready_q;
    assign err = (req_size_i == 2'b11)
               | ((req_size_i == 2'b01) & req_addr_i[0])
               | ((req_size_i == 2'b10) & (|req_addr_i[1:0]))
               | (|req_addr_i[31:ADDR_W]);

    // Next state and next output values; every output is registered from these
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr2_d        = wr2_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_size_d   = mem_size_q;
        mem_sign_d   = mem_sign_q;
        mem_write_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        case (state_q)
            IDLE: if (accept) begin
                cnt_d       = '0;
                wr2_d       = 1'b0;
                mem_addr_d  = req_addr_i[ADDR_W-1:0];
                mem_wdata_d = req_wdata_i;
                mem_size_d  = req_size_i;
                mem_sign_d  = req_sign_i;
                if (err) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else if (req_write_i) begin
                    state_d     = WR;
                    mem_write_d = 1'b1;
                end else begin
                    state_d = RD;
                end
            end
            RD: if (cnt_q == LAT) begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = mem_rdata_i;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            WR: if (wr2_q) begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end else begin
                wr2_d       = 1'b1;
                mem_write_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr2_q        <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_size_q   <= '0;
            mem_sign_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr2_q        <= wr2_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_size_q   <= mem_size_d;
            mem_sign_q   <= mem_sign_d;
            mem_write_q  <= mem_write_d;
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_size_o   = mem_size_q;
    assign mem_sign_o   = mem_sign_q;
    assign mem_write_o  = mem_write_q;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed checks of lsu latency, error detection, store pulse width, back-to-back and reset abort
module tb_lsu;
    logic        clk, rst_n;
    logic        req_valid, req_ready, req_write, req_sign;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [1:0]  mem_size;
    logic        mem_sign, mem_write;
    int          n_chk = 0;
    int          n_pass = 0;
    int          lat, nw;

    lsu dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_size_i(req_size), .req_sign_i(req_sign), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_size_o(mem_size),
        .mem_sign_o(mem_sign), .mem_write_o(mem_write), .mem_rdata_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int l, output int n);
        req_valid = 1'b1; req_write = w; req_size = sz; req_sign = sg; req_addr = a; req_wdata = wd;
        step();
        req_valid = 1'b0;
        l = 1;
        n = int'(mem_write);
        while (!resp_valid && l < 20) begin
            step();
            l++;
            n += int'(mem_write);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_sign = 1'b0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0;
        repeat (3) step();
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_rdata", resp_rdata, 0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 32'(req_ready), 1);

        mem_rdata = 32'hDEADBEEF;
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, nw);
        chk("ldw_lat", 32'(lat), 4);
        chk("ldw_rdata", resp_rdata, 32'hDEADBEEF);
        chk("ldw_err", 32'(resp_err), 0);
        chk("ldw_addr", 32'(mem_addr), 32'h10);
        chk("ldw_nwrite", 32'(nw), 0);
        chk("ldw_ready_in_resp", 32'(req_ready), 0);
        step();
        chk("ldw_resp_one_cycle", 32'(resp_valid), 0);
        chk("ldw_ready_back", 32'(req_ready), 1);

        issue(1'b1, 2'b00, 1'b0, 32'h3, 32'hA5, lat, nw);
        chk("stb_lat", 32'(lat), 3);
        chk("stb_nwrite", 32'(nw), 2);
        chk("stb_addr", 32'(mem_addr), 32'h3);
        chk("stb_size", 32'(mem_size), 0);
        chk("stb_wdata", mem_wdata, 32'hA5);
        chk("stb_rdata", resp_rdata, 0);
        chk("stb_err", 32'(resp_err), 0);
        chk("stb_write_in_resp", 32'(mem_write), 0);
        step();

        issue(1'b0, 2'b01, 1'b0, 32'h1, 32'h0, lat, nw);
        chk("ldh_mis_lat", 32'(lat), 1);
        chk("ldh_mis_err", 32'(resp_err), 1);
        chk("ldh_mis_rdata", resp_rdata, 0);
        step();

        issue(1'b1, 2'b10, 1'b0, 32'h4000, 32'h12345678, lat, nw);
        chk("stw_oob_lat", 32'(lat), 1);
        chk("stw_oob_err", 32'(resp_err), 1);
        chk("stw_oob_nwrite", 32'(nw), 0);
        step();

        issue(1'b1, 2'b10, 1'b0, 32'h6, 32'h1, lat, nw);
        chk("stw_mis_err", 32'(resp_err), 1);
        chk("stw_mis_nwrite", 32'(nw), 0);
        step();

        issue(1'b0, 2'b11, 1'b0, 32'h8, 32'h0, lat, nw);
        chk("size11_lat", 32'(lat), 1);
        chk("size11_err", 32'(resp_err), 1);
        chk("size11_rdata", resp_rdata, 0);
        step();

        mem_rdata = 32'hFFFF8001;
        issue(1'b0, 2'b01, 1'b1, 32'h2, 32'h0, lat, nw);
        chk("ldh_s_lat", 32'(lat), 4);
        chk("ldh_s_sign", 32'(mem_sign), 1);
        chk("ldh_s_size", 32'(mem_size), 1);
        chk("ldh_s_rdata", resp_rdata, 32'hFFFF8001);
        step();

        mem_rdata = 32'h0BADF00D;
        issue(1'b0, 2'b10, 1'b0, 32'h3FFC, 32'h0, lat, nw);
        chk("ldw_top_lat", 32'(lat), 4);
        chk("ldw_top_err", 32'(resp_err), 0);
        chk("ldw_top_addr", 32'(mem_addr), 32'h3FFC);
        step();

        begin
            int acc, nresp, bad;
            acc = 0; nresp = 0; bad = 0;
            req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h20;
            for (int i = 0; i < 25; i++) begin
                if (acc == 3) req_valid = 1'b0;
                if (req_valid && req_ready) acc++;
                step();
                if (resp_valid) nresp++;
                if (resp_valid && req_ready) bad++;
            end
            req_valid = 1'b0;
            chk("b2b_accepts", 32'(acc), 3);
            chk("b2b_resps", 32'(nresp), 3);
            chk("b2b_ready_in_resp", 32'(bad), 0);
        end

        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h40; req_wdata = 32'h55;
        step();
        req_valid = 1'b0;
        chk("abort_wr1", 32'(mem_write), 1);
        rst_n = 1'b0;
        step();
        chk("abort_write", 32'(mem_write), 0);
        chk("abort_ready", 32'(req_ready), 0);
        chk("abort_resp", 32'(resp_valid), 0);
        rst_n = 1'b1;
        step();
        chk("abort_ready_back", 32'(req_ready), 1);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 5; i++) begin
                step();
                seen += int'(resp_valid) + int'(mem_write);
            end
            chk("abort_quiet", 32'(seen), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The module SHALL take parameter READ_LAT, default 2, the number of clock edges from a stable memory address to valid mem_rdata.
REQ-002 The module SHALL take parameter ADDR_W, default 14, the byte-address width of the 16KB memory.
REQ-003 clk  in  1  the only clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 req_valid  in  1  core presents a request.
REQ-006 req_ready  out  1  LSU can accept a request this cycle.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  encoding: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 req_sign  in  1  1 = sign-extend the load result.
REQ-010 req_addr  in  32  byte address.
REQ-011 req_wdata  in  32  store data, right-aligned.
REQ-012 resp_valid  out  1  single-cycle completion pulse.
REQ-013 resp_rdata  out  32  load result; 0 for stores and errors.
REQ-014 resp_err  out  1  request was rejected without any memory access.
REQ-015 mem_addr  out  ADDR_W  data-port byte address.
REQ-016 mem_wdata  out  32  data-port store data.
REQ-017 mem_size  out  2  data-port access size, same encoding as req_size.
REQ-018 mem_sign  out  1  data-port sign-extend flag.
REQ-019 mem_write  out  1  data-port write enable.
REQ-020 mem_rdata  in  32  data-port read data, already aligned and extended by memory.

Function
REQ-021 All outputs SHALL be registered.
REQ-022 The state machine SHALL have four states: IDLE, RD, WR, RESP.
REQ-023 req_ready SHALL be 1 only in IDLE.
REQ-024 A request SHALL be accepted on an edge where req_valid & req_ready; only one request is outstanding at a time.
REQ-025 On accept, the LSU SHALL capture addr, size, sign, write and wdata into internal registers; mem_addr SHALL equal req_addr[ADDR_W-1:0].
REQ-026 A request SHALL be an error when any of the following holds:
- req_size == 11
- half access with addr[0] == 1
- word access with addr[1:0] != 0
- req_addr[31:ADDR_W] != 0
REQ-027 On an error request: IDLE->RESP, no mem_write, resp_err = 1, resp_rdata = 0.
REQ-028 On a legal load: IDLE->RD, mem_write = 0, mem_addr/mem_size/mem_sign held stable for READ_LAT+1 cycles.
REQ-029 On the final RD edge, the LSU SHALL capture mem_rdata into resp_rdata, then go RD->RESP.
REQ-030 On a legal store: IDLE->WR, mem_write = 1 for exactly 2 consecutive cycles with mem_addr/mem_wdata/mem_size held stable, then WR->RESP with resp_rdata = 0.
REQ-031 The memory registers write data internally; the first of the two write cycles MAY store stale data, and the second SHALL leave the correct final value.
REQ-032 RESP SHALL last exactly one cycle with resp_valid = 1, then return to IDLE; there is no response backpressure.
REQ-033 Latency from the accept edge to the first cycle of resp_valid: error = 1 edge; store = 3 edges; load = READ_LAT+2 edges.
REQ-034 A request presented while req_ready = 0 SHALL be ignored and not queued.
REQ-035 Back-to-back requests: req_ready SHALL return to 1 in the cycle after RESP.
REQ-036 In IDLE and RESP, mem_write SHALL be 0; mem_addr/mem_size/mem_sign/mem_wdata SHALL hold their last values.
REQ-037 An RD cycle counter SHALL saturate at READ_LAT, be cleared on accept, and never wrap.

Reset
REQ-038 While rst_n = 0 at an edge, the LSU SHALL set state = IDLE and req_ready = 0, and set to 0: resp_valid, resp_err, resp_rdata, all mem_* outputs, and the counter.
REQ-039 req_ready SHALL be 1 in the first cycle after rst_n is sampled high.
REQ-040 Reset asserted mid-operation SHALL abort at that edge: mem_write drops immediately, no resp_valid is issued, and a partially performed store is tolerated.

Verification
REQ-041 Word load at 0x0000_0010 with mem_rdata = 0xDEADBEEF -> mem_addr = 0x0010; resp_valid in the 4th cycle after accept (READ_LAT = 2) with resp_rdata = 0xDEADBEEF, resp_err = 0.
REQ-042 Store byte 0xA5 at 0x0000_0003 -> mem_write high 2 cycles with mem_addr = 0x0003, mem_size = 00; resp_valid 3 edges after accept with resp_rdata = 0.
REQ-043 Half load at 0x0000_0001, and word store at 0x0000_4000 -> resp_err = 1 one edge after accept; mem_write never asserted.
REQ-044 req_valid held high continuously with 3 loads -> each accepted only in IDLE; exactly 3 resp_valid pulses; req_ready low during RD/RESP.
REQ-045 rst_n low during the 1st WR cycle -> next cycle mem_write = 0, state IDLE, no resp_valid; req_ready = 1 one cycle after release.
REQ-046 req_size = 11 at an aligned address -> resp_err = 1, resp_rdata = 0.
